// File: rtl/rv_mem_arb_if.sv
// Bus bundle for rv_mem_arb: fetch and data requester handshakes plus the
// single synchronous-read memory port. slave = arbiter view, master = environment view.
interface rv_mem_arb_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;

  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic              d_wr_en;
  logic [31:0]       d_wr_data;
  logic [3:0]        d_byte_en;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;

  logic [31:0]       mem_addr;
  logic              mem_wr_en;
  logic [31:0]       mem_wr_data;
  logic [3:0]        mem_byte_en;
  logic [31:0]       mem_rd_data;

  modport slave (
    input  if_req, if_addr, d_req, d_addr, d_wr_en, d_wr_data, d_byte_en, mem_rd_data,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_addr, mem_wr_en, mem_wr_data, mem_byte_en
  );

  modport master (
    output if_req, if_addr, d_req, d_addr, d_wr_en, d_wr_data, d_byte_en, mem_rd_data,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_addr, mem_wr_en, mem_wr_data, mem_byte_en
  );
endinterface

// File: rtl/rv_mem_arb.sv
// Unified-memory arbiter: data has priority over fetch, one grant per cycle, read data routed back one cycle later.
// Define MEM_ARB_ANTI_STARVE_EN to add the fetch starvation guard (counter + FETCH_PRI state).
//   state     | meaning
//   DATA_PRI  | data request wins contention (reset state)
//   FETCH_PRI | fetch request wins contention, entered after STARVE_LIMIT denied fetch cycles
module rv_mem_arb #(
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic         clk,
  input logic         rst,
  rv_mem_arb_if.slave bus
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("rv_mem_arb: STARVE_LIMIT must be in 1..15");
  end

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_e;

  owner_e            owner_q, owner_d;
  logic              if_gnt, d_gnt;
  logic [ADDR_W-1:0] sel_addr;

`ifdef MEM_ARB_ANTI_STARVE_EN
  typedef enum logic {DATA_PRI, FETCH_PRI} state_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e     state_q, state_d;
  logic [3:0] starve_q, starve_d;

  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (rst) begin
      if (state_q == FETCH_PRI) begin
        if_gnt = bus.if_req;
        d_gnt  = !bus.if_req && bus.d_req;
      end else begin
        d_gnt  = bus.d_req;
        if_gnt = !bus.d_req && bus.if_req;
      end
    end
    if (if_gnt || !bus.if_req) begin
      starve_d = 4'd0;
    end else if (starve_q >= LIMIT) begin
      starve_d = LIMIT;
    end else begin
      starve_d = starve_q + 4'd1;
    end
    // Look at the next count so fetch wins in the cycle right after the limit is reached.
    state_d = (starve_d == LIMIT) ? FETCH_PRI : DATA_PRI;
  end
`else
  always_comb begin
    d_gnt  = rst && bus.d_req;
    if_gnt = rst && !bus.d_req && bus.if_req;
  end
`endif

  always_comb begin
    owner_d = OWN_NONE;
    if (if_gnt) begin
      owner_d = OWN_IF;
    end else if (d_gnt && !bus.d_wr_en) begin
      owner_d = OWN_D;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q  <= OWN_NONE;
`ifdef MEM_ARB_ANTI_STARVE_EN
      state_q  <= DATA_PRI;
      starve_q <= 4'd0;
`endif
    end else begin
      owner_q  <= owner_d;
`ifdef MEM_ARB_ANTI_STARVE_EN
      state_q  <= state_d;
      starve_q <= starve_d;
`endif
    end
  end

  // Idle cycles present the fetch address as a harmless read.
  assign sel_addr = d_gnt ? bus.d_addr : bus.if_addr;

  assign bus.if_gnt      = if_gnt;
  assign bus.d_gnt       = d_gnt;
  assign bus.mem_addr    = rst ? 32'(sel_addr >> 2) : 32'd0;
  assign bus.mem_wr_en   = d_gnt && bus.d_wr_en;
  assign bus.mem_wr_data = bus.d_wr_data;
  assign bus.mem_byte_en = d_gnt ? bus.d_byte_en : 4'b1111;

  assign bus.if_rvalid = (owner_q == OWN_IF);
  assign bus.d_rvalid  = (owner_q == OWN_D);
  assign bus.if_rdata  = bus.mem_rd_data;
  assign bus.d_rdata   = bus.mem_rd_data;

endmodule

// File: tb/tb_rv_mem_arb.sv
// Self-checking bench for rv_mem_arb: directed scenarios followed by random traffic against a rule-level model.
module tb_rv_mem_arb;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rv_mem_arb_if #(.ADDR_W(32)) bus ();

  rv_mem_arb #(.ADDR_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] init_word(input int i);
    return 32'hA5A5_0000 ^ (32'(i) * 32'h9E37_79B1);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Synchronous-read memory standing in for rv_mem (write, then registered read of old/new word).
  logic [31:0] mem [0:63];
  bit          written [0:63];
  always @(posedge clk) begin
    int          idx;
    logic [31:0] cur;
    idx = int'(bus.mem_addr[5:0]);
    cur = written[idx] ? mem[idx] : init_word(idx);
    if (bus.mem_wr_en) begin
      mem[idx]     <= merge(cur, bus.mem_wr_data, bus.mem_byte_en);
      written[idx] <= 1'b1;
    end
    bus.mem_rd_data <= cur;
  end

  // Reference model state
  logic [31:0] ref_mem [0:63];
  int          denied = 0;
  bit          last_fg = 1'b0;
  bit          last_dg = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge with inputs driven; returns at the next falling edge.
  task automatic step();
    bit          fg, dg, due;
    int          widx;
    logic [31:0] exp_addr, exp_word;
`ifdef MEM_ARB_ANTI_STARVE_EN
    due = (denied >= LIMIT);
`else
    due = 1'b0;
`endif
    fg = 1'b0;
    dg = 1'b0;
    if (rst) begin
      if (bus.d_req && !(bus.if_req && due)) dg = 1'b1;
      else if (bus.if_req) fg = 1'b1;
    end
    exp_addr = !rst ? 32'd0 : ((dg ? bus.d_addr : bus.if_addr) >> 2);
    #2;
    chk("if_gnt", bus.if_gnt, fg);
    chk("d_gnt", bus.d_gnt, dg);
    chk("mem_addr", bus.mem_addr, exp_addr);
    chk("mem_wr_en", bus.mem_wr_en, dg && bus.d_wr_en);
    chk("mem_byte_en", bus.mem_byte_en, dg ? bus.d_byte_en : 4'hF);
    widx     = int'(exp_addr[5:0]);
    exp_word = ref_mem[widx];
    @(posedge clk);
    #1;
    chk("if_rvalid", bus.if_rvalid, fg);
    chk("d_rvalid", bus.d_rvalid, dg && !bus.d_wr_en);
    if (fg) chk("if_rdata", bus.if_rdata, exp_word);
    if (dg && !bus.d_wr_en) chk("d_rdata", bus.d_rdata, exp_word);
    if (dg && bus.d_wr_en) ref_mem[widx] = merge(ref_mem[widx], bus.d_wr_data, bus.d_byte_en);
    if (!rst || !bus.if_req || fg) denied = 0;
    else denied++;
    last_fg = fg;
    last_dg = dg;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bit exp_if;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);

    // Reset: requests pending but everything must sit at reset values.
    bus.if_req    = 1'b1;
    bus.if_addr   = 32'h44;
    bus.d_req     = 1'b1;
    bus.d_addr    = 32'h88;
    bus.d_wr_en   = 1'b1;
    bus.d_wr_data = 32'h1234_5678;
    bus.d_byte_en = 4'h3;
    #2;
    chk("rst_if_gnt", bus.if_gnt, 1'b0);
    chk("rst_d_gnt", bus.d_gnt, 1'b0);
    chk("rst_mem_wr_en", bus.mem_wr_en, 1'b0);
    chk("rst_mem_byte_en", bus.mem_byte_en, 4'hF);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_if_rvalid", bus.if_rvalid, 1'b0);
    chk("rst_d_rvalid", bus.d_rvalid, 1'b0);
    @(negedge clk);
    chk("rst_edge_d_rvalid", bus.d_rvalid, 1'b0);
    rst        = 1'b1;
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;

    // Fetch only
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h10;
    #1;
    chk("fetch_mem_addr", bus.mem_addr, 32'h4);
    step();
    chk("fetch_rvalid", bus.if_rvalid, 1'b1);
    chk("fetch_word", bus.if_rdata, init_word(4));
    bus.if_req = 1'b0;

    // Data write then read of the same address
    bus.d_req     = 1'b1;
    bus.d_addr    = 32'h20;
    bus.d_wr_en   = 1'b1;
    bus.d_wr_data = 32'hDEAD_BEEF;
    bus.d_byte_en = 4'b0011;
    step();
    bus.d_wr_en = 1'b0;
    step();
    chk("raw_rvalid", bus.d_rvalid, 1'b1);
    chk("raw_lo", bus.d_rdata[15:0], 16'hBEEF);

    // Contention with both requests held high
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h04;
    bus.d_addr  = 32'h08;
    for (int c = 0; c < 10; c++) begin
`ifdef MEM_ARB_ANTI_STARVE_EN
      exp_if = (c % 5 == 4);
`else
      exp_if = 1'b0;
`endif
      #1;
      chk("cont_if_gnt", bus.if_gnt, exp_if);
      step();
    end
    bus.d_req = 1'b0;
    #1;
    chk("cont_drop_if_gnt", bus.if_gnt, 1'b1);
    step();

    // Alternating owner
    bus.if_addr = 32'h40;
    step();
    bus.if_req = 1'b0;
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h44;
    step();
    bus.d_req = 1'b0;
    step();

    // Reset while a fetch read is in flight
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h30;
    #2;
    chk("rr_if_gnt", bus.if_gnt, 1'b1);
    #1;
    rst = 1'b0;
    #1;
    chk("rr_forced_if_gnt", bus.if_gnt, 1'b0);
    chk("rr_mem_addr", bus.mem_addr, 32'd0);
    chk("rr_mem_byte_en", bus.mem_byte_en, 4'hF);
    @(posedge clk);
    #1;
    chk("rr_if_rvalid", bus.if_rvalid, 1'b0);
    @(negedge clk);
    rst         = 1'b1;
    bus.if_req  = 1'b0;
    bus.if_addr = 32'h0;
    denied      = 0;
    last_fg     = 1'b0;
    last_dg     = 1'b0;
    #1;
    chk("rr_post_if_rvalid", bus.if_rvalid, 1'b0);
    step();
    step();

    // Random traffic; pending requests mostly held until granted
    for (int n = 0; n < 400; n++) begin
      if (!bus.if_req || last_fg || $urandom_range(0, 7) == 0) begin
        bus.if_req  = ($urandom_range(0, 3) != 0);
        bus.if_addr = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      end
      if (!bus.d_req || last_dg || $urandom_range(0, 7) == 0) begin
        bus.d_req     = ($urandom_range(0, 2) != 0);
        bus.d_addr    = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
        bus.d_wr_en   = ($urandom_range(0, 2) == 0);
        bus.d_wr_data = $urandom;
        bus.d_byte_en = 4'($urandom_range(0, 15));
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
